// File: rtl/left_shifter_seq_if.sv
// Bus bundle for the sequential left shift/rotate unit.
//
// Handshake: start acts as a request valid with an implicit ready of
// (busy == 0). A request is accepted on any rising edge where start is
// high and the unit is not shifting (IDLE or DONE). A request presented
// while busy is dropped, not queued. done is the response valid; it is
// high for exactly one cycle and y is stable from that cycle until the
// next done or reset. The requester is not required to acknowledge done.
//
// state mirrors the FSM encoding (0 = IDLE, 1 = SHIFT, 2 = DONE) so
// checkers can bind to it without reaching into the design.
interface left_shifter_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             rotate;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  // Requester side: drives the operation, observes result and status.
  modport master (
    output start, a, amt, rotate,
    input  y, busy, done, state
  );

  // Shifter side: consumes the operation, produces result and status.
  modport slave (
    input  start, a, amt, rotate,
    output y, busy, done, state
  );
endinterface

// File: rtl/left_shifter_seq.sv
// Sequential left shift / rotate unit. Captures an operand, a shift
// amount and a mode on an accepted start, moves the operand one bit per
// clock, then publishes the result in y together with a one-cycle done.
// busy and done are decoded from the state register, so both are
// glitch-free and can never be high together.
module left_shifter_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  left_shifter_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] y_q, y_d;

  // One-position left move; the vacated LSB takes the old MSB when
  // rotating and zero for a logical shift (the MSB is discarded).
  logic [WIDTH-1:0] sh_next;
  assign sh_next = {sh_q[WIDTH-2:0], (mode_q ? sh_q[WIDTH-1] : 1'b0)};

  // State and datapath registers; reset aborts any operation and clears y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
    end
  end

  // Next-state and datapath update. DONE accepts a new start exactly like
  // IDLE so that back-to-back operations lose no cycle. cnt reaching zero
  // ends the shift phase, so the down-counter never wraps.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sh_d    = bus.a;
          cnt_d   = bus.amt;
          mode_d  = bus.rotate;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sh_d  = sh_next;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          y_d     = sh_q;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.y     = y_q;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_left_shifter_seq.sv
// Bench for left_shifter_seq: directed scenarios plus an exhaustive
// operand/amount/mode sweep, with a result/latency scoreboard.
module tb_left_shifter_seq;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  logic [7:0] exp_q[$];
  int         due_q[$];
  logic [7:0] last_y;

  left_shifter_seq_if #(.WIDTH(8), .AMT_W(3)) bus ();

  left_shifter_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Golden model, written as a 16-bit window rather than a bit loop.
  function automatic logic [7:0] model(input logic [7:0] av,
                                       input logic [2:0] amv,
                                       input logic rv);
    logic [15:0] w;
    if (rv) begin
      w = {av, av} << amv;
      return w[15:8];
    end else begin
      w = {8'h00, av} << amv;
      return w[7:0];
    end
  endfunction

  // Scoreboard monitor: done pairs with the oldest expected entry, checks
  // value and cycle of arrival; between results y must hold.
  always @(negedge clk) begin
    logic [7:0] e;
    int d;
    if (reset) begin
      last_y = 8'h00;
    end else begin
      checks++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both", bus.busy, bus.done);
      end
      if (bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done: actual=done with empty queue required=no done");
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if (bus.y !== e) begin
            errors++;
            $display("FAIL result_y: actual=%h required=%h", bus.y, e);
          end
          checks++;
          if (cyc !== d) begin
            errors++;
            $display("FAIL latency: done at cycle %0d required %0d", cyc, d);
          end
          last_y = e;
        end
      end else begin
        if (bus.y !== last_y) begin
          errors++;
          $display("FAIL y_hold: actual=%h required=%h", bus.y, last_y);
        end
      end
    end
  end

  // Driver: called at a negedge with the unit idle or in DONE; the next
  // rising edge is the accepting edge.
  task automatic issue(input logic [7:0] av, input logic [2:0] amv, input logic rv);
    bus.start  = 1'b1;
    bus.a      = av;
    bus.amt    = amv;
    bus.rotate = rv;
    @(posedge clk);
    #1;
    exp_q.push_back(model(av, amv, rv));
    due_q.push_back(cyc + int'(amv) + 1);
    bus.start = 1'b0;
    bus.a     = $urandom_range(0, 255);
    bus.amt   = $urandom_range(0, 7);
    bus.rotate = $urandom_range(0, 1);
  endtask

  // Returns at the negedge where done is high, or reports a timeout.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: actual=no done in 20 cycles required=done");
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.y, bus.state} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b y=%h state=%0d required all 0",
               bus.busy, bus.done, bus.y, bus.state);
    end
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(8'h06, 3'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy1: busy=%0b done=%0b required busy=1 done=0", bus.busy, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy2: busy=%0b done=%0b required busy=1 done=0", bus.busy, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.y !== 8'h0C) begin
      errors++;
      $display("FAIL basic_done: busy=%0b done=%0b y=%h required busy=0 done=1 y=0c",
               bus.busy, bus.done, bus.y);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.state !== 2'd0) begin
      errors++;
      $display("FAIL basic_pulse: done=%0b state=%0d required done=0 state=0", bus.done, bus.state);
    end
  endtask

  task automatic test_rotate();
    issue(8'h81, 3'd3, 1'b1);
    wait_done();
    @(negedge clk);
    issue(8'h81, 3'd3, 1'b0);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_extremes();
    issue(8'hFF, 3'd7, 1'b0);
    wait_done();
    @(negedge clk);
    issue(8'h5A, 3'd0, 1'b0);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(8'h01, 3'd4, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hF0;
    bus.amt   = 3'd1;
    @(negedge clk);
    bus.a = 8'hAA;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    issue(8'h03, 3'd2, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.y !== 8'h10) begin
      errors++;
      $display("FAIL b2b_accept: busy=%0b y=%h required busy=1 y=10", bus.busy, bus.y);
    end
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    issue(8'h11, 3'd6, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y !== 8'h00 || bus.state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b done=%0b y=%h state=%0d required all 0",
               bus.busy, bus.done, bus.y, bus.state);
    end
    exp_q.delete();
    due_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    issue(8'h11, 3'd1, 1'b0);
    wait_done();
    checks++;
    if (bus.y !== 8'h22) begin
      errors++;
      $display("FAIL post_reset_y: actual=%h required=22", bus.y);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    for (int av = 0; av < 256; av++) begin
      for (int am = 0; am < 8; am++) begin
        for (int rv = 0; rv < 2; rv++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          issue(8'(av), 3'(am), 1'(rv));
          wait_done();
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    last_y     = 8'h00;
    bus.start  = 1'b0;
    bus.a      = 8'h00;
    bus.amt    = 3'd0;
    bus.rotate = 1'b0;
    test_reset();
    test_basic();
    test_rotate();
    test_extremes();
    test_back_to_back();
    test_reset_mid_shift();
    test_sweep();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: actual=%0d pending results required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
